// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table sweep engine: FSM state encodings
// and the hold-counter width helper.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } tt_state_e;

  // A counter reaching HOLD-1 needs $clog2(HOLD) bits, but never fewer than one.
  function automatic int hold_w(input int hold);
    int w;
    w = $clog2(hold);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/truth_table_checker_hold_timer.sv
// Hold-window counter: counts 0..HOLD-1 while enabled, wraps, and flags the
// last cycle of each window.
module hold_timer
  import truth_table_checker_pkg::*;
#(
  parameter int HOLD = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int W = hold_w(HOLD);
  localparam logic [W-1:0] LAST_CNT = W'(HOLD - 1);

  logic [W-1:0] cnt;

  assign last = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweep: drives every input code for HOLD cycles,
// samples the DUT output at the end of each window and tallies mismatches.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int HOLD = 20,
  parameter logic [2**N_IN-1:0] EXPECT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_f,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;

  tt_state_e state, state_d;
  logic      launch;
  logic      sample;
  logic      mismatch;
  logic      last;
  logic      timer_en;
  logic      timer_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Abort takes priority over the end-of-window sample, so an aborted
  // window never contributes to the result registers.
  always_comb begin
    state_d = state;
    launch  = 1'b0;
    sample  = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          launch  = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last) begin
          sample = 1'b1;
          if (vec == VEC_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The timer sits at zero outside DRIVE so the first window starts cleanly.
  assign timer_en    = (state == ST_DRIVE);
  assign timer_clear = (state != ST_DRIVE) || abort;

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .en    (timer_en),
    .last  (last)
  );

  // dut_f is compared unregistered: it is a combinational function of vec.
  assign mismatch = sample && (dut_f != EXPECT[vec]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
    end else if (launch) begin
      vec <= '0;
    end else if ((state == ST_DRIVE) && abort) begin
      vec <= '0;
    end else if (sample && (vec != VEC_LAST)) begin
      vec <= vec + N_IN'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else if (launch) begin
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else if (mismatch) begin
      err_count <= err_count + (N_IN+1)'(1);
      if (!first_fail_valid) begin
        first_fail       <= vec;
        first_fail_valid <= 1'b1;
      end
    end
  end

  assign busy = (state == ST_DRIVE);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with a queue-based result scoreboard.
module tb_truth_table_checker;

  typedef struct {
    int err;
    int ff;
    int ffv;
    int pass;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance A: 2-input AND/OR under test, HOLD=20
  logic       start_a = 1'b0, abort_a = 1'b0, or_mode = 1'b0;
  logic       dut_f_a;
  logic [1:0] vec_a;
  logic       busy_a, done_a, pass_a, ffv_a;
  logic [2:0] err_a;
  logic [1:0] ff_a;

  assign dut_f_a = or_mode ? (vec_a[0] | vec_a[1]) : (vec_a[0] & vec_a[1]);

  truth_table_checker #(.N_IN(2), .HOLD(20), .EXPECT(4'b1000)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .dut_f(dut_f_a),
    .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail(ff_a), .first_fail_valid(ffv_a)
  );

  // Instance B: output tied low against an all-ones table, HOLD=1
  logic       start_b = 1'b0, abort_b = 1'b0;
  logic [2:0] vec_b;
  logic       busy_b, done_b, pass_b, ffv_b;
  logic [3:0] err_b;
  logic [2:0] ff_b;

  truth_table_checker #(.N_IN(3), .HOLD(1), .EXPECT(8'hFF)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .dut_f(1'b0),
    .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail(ff_b), .first_fail_valid(ffv_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   start_edge_a = 0, start_edge_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  logic done_a_prev = 1'b0;
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a && !done_a_prev) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        chk("a_err_count", err_a, e.err);
        chk("a_first_fail_valid", ffv_a, e.ffv);
        if (e.ffv != 0) chk("a_first_fail", ff_a, e.ff);
        chk("a_pass", pass_a, e.pass);
        chk("a_busy_at_done", busy_a, 0);
        chk("a_latency", cyc - start_edge_a, e.lat);
      end
    end
    done_a_prev = done_a;
  end

  logic done_b_prev = 1'b0;
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b && !done_b_prev) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        chk("b_err_count", err_b, e.err);
        chk("b_first_fail_valid", ffv_b, e.ffv);
        if (e.ffv != 0) chk("b_first_fail", ff_b, e.ff);
        chk("b_pass", pass_b, e.pass);
        chk("b_vec_held", vec_b, 7);
        chk("b_latency", cyc - start_edge_b, e.lat);
      end
    end
    done_b_prev = done_b;
  end

  // Each start task returns #1 after the edge that sampled start.
  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_edge_a = cyc;
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_edge_b = cyc;
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int max_cyc);
    int n = 0;
    while (!done_a && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("a_done_timeout", done_a, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done_b(input int max_cyc);
    int n = 0;
    while (!done_b && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_done_timeout", done_b, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic abort_at_vec2(input logic mode, input logic with_start,
                               input int exp_err, input int exp_ffv);
    or_mode = mode;
    pulse_start_a();
    repeat (45) @(posedge clk);
    #1;
    chk("abort_pre_vec", vec_a, 2);
    @(negedge clk);
    abort_a = 1'b1;
    start_a = with_start;
    @(posedge clk);
    #1;
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_vec", vec_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_pass", pass_a, 0);
    chk("abort_err_kept", err_a, exp_err);
    chk("abort_ffv_kept", ffv_a, exp_ffv);
    if (exp_ffv != 0) chk("abort_ff_kept", ff_a, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", busy_a, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_vec", vec_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_ff", ff_a, 0);
    chk("rst_ffv", ffv_a, 0);
    chk("rst_b_err", err_b, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // HOLD=1, every vector fails: 8 errors in 4 bits, first fail at 0
    q_b.push_back('{err: 8, ff: 0, ffv: 1, pass: 0, lat: 8});
    pulse_start_b();
    chk("b_busy_after_start", busy_b, 1);
    wait_done_b(40);

    // AND sweep with vector timing and an ignored mid-sweep start
    or_mode = 1'b0;
    q_a.push_back('{err: 0, ff: 0, ffv: 0, pass: 1, lat: 80});
    pulse_start_a();
    chk("s1_busy", busy_a, 1);
    for (int i = 0; i < 4; i++) begin
      chk("s1_vec_window_start", vec_a, i);
      if (i == 1) begin
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (18) @(posedge clk);
      end else begin
        repeat (19) @(posedge clk);
      end
      #1;
      chk("s1_vec_window_end", vec_a, i);
      chk("s1_done_low", done_a, 0);
      @(posedge clk);
      #1;
    end
    chk("s1_done", done_a, 1);
    chk("s1_busy_fall", busy_a, 0);
    chk("s1_vec_held", vec_a, 3);
    wait_done_a(10);

    // abort in DONE is a no-op
    @(negedge clk);
    abort_a = 1'b1;
    @(posedge clk);
    #1;
    abort_a = 1'b0;
    chk("abort_in_done", done_a, 1);

    // restart from DONE: results clear on the start edge, same outcome
    q_a.push_back('{err: 0, ff: 0, ffv: 0, pass: 1, lat: 80});
    pulse_start_a();
    chk("s2_done_cleared", done_a, 0);
    chk("s2_busy", busy_a, 1);
    chk("s2_vec", vec_a, 0);
    wait_done_a(120);

    // OR under an AND table: vectors 1 and 2 fail
    or_mode = 1'b1;
    q_a.push_back('{err: 2, ff: 1, ffv: 1, pass: 0, lat: 80});
    pulse_start_a();
    chk("s3_err_cleared", err_a, 0);
    chk("s3_ffv_cleared", ffv_a, 0);
    wait_done_a(120);

    abort_at_vec2(1'b0, 1'b0, 0, 0);
    abort_at_vec2(1'b1, 1'b1, 1, 1);

    // fresh AND sweep after aborts restarts err_count from 0
    or_mode = 1'b0;
    q_a.push_back('{err: 0, ff: 0, ffv: 0, pass: 1, lat: 80});
    pulse_start_a();
    chk("s4_err_restart", err_a, 0);
    chk("s4_ffv_restart", ffv_a, 0);
    wait_done_a(120);

    // asynchronous reset mid-hold of vec=1
    pulse_start_a();
    repeat (25) @(posedge clk);
    #3;
    chk("prerst_vec", vec_a, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_vec", vec_a, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_done", done_a, 0);
    chk("async_rst_pass", pass_a, 0);
    chk("async_rst_err", err_a, 0);
    chk("async_rst_ffv", ffv_a, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", busy_a, 0);
    chk("post_rst_idle_vec", vec_a, 0);
    chk("post_rst_no_done", done_a, 0);

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
